// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encodings and default baud divisor for the UART blocks.
package uart_tx_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter, ticks in the last cycle of every bit.
module uart_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] clk_cnt;
  assign o_tick = clk_cnt == LAST;
  always_ff @(posedge i_clk)
    clk_cnt <= (i_rst || i_clear || o_tick) ? '0 : clk_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: drains bytes over valid/ready and shifts them out as UART frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_idx;
  logic                 par;
  logic                 tick;
  logic                 fire;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state == ST_IDLE),
    .o_tick  (tick)
  );
  // Accepting in the final stop cycle lets the next start bit follow with no gap.
  assign o_ready = state == ST_IDLE || (state == ST_STOP && bit_idx == LAST_STOP && tick);
  assign o_busy  = state != ST_IDLE;
  assign fire    = i_valid && o_ready;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      o_tx    <= 1'b1;
    end else if (fire) begin
      state   <= ST_START;
      shift   <= i_data;
      par     <= (PARITY_ODD != 0) ? ~^i_data : ^i_data;
      bit_idx <= '0;
      o_tx    <= 1'b0;
    end else if (tick)
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          bit_idx <= '0;
          o_tx    <= shift[0];
        end
        ST_DATA: begin
          shift   <= shift >> 1;
          bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 1'b1;
          state   <= (bit_idx != LAST_DATA) ? ST_DATA : (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          o_tx    <= (bit_idx != LAST_DATA) ? shift[1] : (PARITY_EN != 0) ? par : 1'b1;
        end
        ST_PARITY: begin
          state   <= ST_STOP;
          bit_idx <= '0;
          o_tx    <= 1'b1;
        end
        ST_STOP: begin
          state   <= (bit_idx == LAST_STOP) ? ST_IDLE : ST_STOP;
          bit_idx <= (bit_idx == LAST_STOP) ? '0 : bit_idx + 1'b1;
          o_tx    <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frame checks of four uart_tx configurations against a bit-level frame model.
module tb_uart_tx;
  localparam int C = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid = '0;
  logic [7:0] data [4];
  logic [3:0] tx, ready, busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tx #(.CLKS_PER_BIT(C)) d0 (.i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .i_data(data[0]), .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) d1 (.i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .i_data(data[1]), .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) d2 (.i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .i_data(data[2]), .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]));
  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) d3 (.i_clk(clk), .i_rst(rst), .i_valid(valid[3]), .i_data(data[3]), .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]));
  function automatic int pe(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction
  function automatic int sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int k);
    return C * (9 + pe(k) + sb(k));
  endfunction
  // Bit b of the frame: start, 8 data LSB first, optional parity, then stop bits.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe(k) == 1 && b == 9) return (($countones(d) + (k == 2 ? 1 : 0)) % 2) == 1;
    return 1'b1;
  endfunction
  task automatic start(input int k, input logic [7:0] d);
    @(negedge clk);
    checks++;
    if (ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL start_ready dut%0d got %b want 1", k, ready[k]);
    end
    valid[k] = 1'b1;
    data[k]  = d;
  endtask
  // Checks one whole frame cycle by cycle; optionally keeps valid high with the next byte queued.
  task automatic run_frame(input int k, input logic [7:0] d, input bit keep_valid, input logic [7:0] nd, input bit scramble);
    int f = flen(k);
    int bt = -1, br = -1, bb = -1;
    logic gt = 1'b0, wt = 1'b0, gr = 1'b0, gb = 1'b0;
    for (int i = 0; i < f; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_valid) valid[k] = 1'b0;
      if (bt < 0 && tx[k] !== exp_bit(k, d, i / C)) begin bt = i; gt = tx[k]; wt = exp_bit(k, d, i / C); end
      if (br < 0 && ready[k] !== (i == f - 1)) begin br = i; gr = ready[k]; end
      if (bb < 0 && busy[k] !== 1'b1) begin bb = i; gb = busy[k]; end
      if (scramble) data[k] = 8'($urandom);
      if (i == f - 1) data[k] = nd;
    end
    checks += 3;
    if (bt >= 0) begin errors++; $display("FAIL frame_tx dut%0d data=%02h cycle %0d got %b want %b", k, d, bt, gt, wt); end
    if (br >= 0) begin errors++; $display("FAIL frame_ready dut%0d data=%02h cycle %0d got %b want %b", k, d, br, gr, br == f - 1); end
    if (bb >= 0) begin errors++; $display("FAIL frame_busy dut%0d data=%02h cycle %0d got %b want 1", k, d, bb, gb); end
  endtask
  task automatic check_idle(input int k, input string name);
    @(negedge clk);
    checks++;
    if ({tx[k], ready[k], busy[k]} !== 3'b110) begin
      errors++;
      $display("FAIL %s dut%0d got tx/ready/busy=%b%b%b want 110", name, k, tx[k], ready[k], busy[k]);
    end
  endtask
  task automatic send(input int k, input logic [7:0] d, input bit scramble);
    start(k, d);
    run_frame(k, d, 1'b0, 8'h00, scramble);
    check_idle(k, "after_frame");
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 3;
    if (tx !== 4'hF) begin errors++; $display("FAIL reset_tx got %b want 1111", tx); end
    if (ready !== 4'hF) begin errors++; $display("FAIL reset_ready got %b want 1111", ready); end
    if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
    rst = 1'b0;
  endtask
  task automatic test_idle;
    logic [3:0] ot = 4'hF, or_ = 4'hF, ob = 4'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ot &= tx; or_ &= ready; ob |= busy;
    end
    checks += 3;
    if (ot !== 4'hF) begin errors++; $display("FAIL idle_tx got %b want 1111", ot); end
    if (or_ !== 4'hF) begin errors++; $display("FAIL idle_ready got %b want 1111", or_); end
    if (ob !== 4'h0) begin errors++; $display("FAIL idle_busy got %b want 0000", ob); end
  endtask
  task automatic test_single;
    send(0, 8'hA5, 1'b0);
    for (int n = 0; n < 4; n++) send(0, 8'($urandom), 1'b1);
  endtask
  task automatic test_back_to_back;
    logic [7:0] q [6];
    q[0] = 8'h00; q[1] = 8'hFF;
    for (int n = 2; n < 6; n++) q[n] = 8'($urandom);
    start(0, q[0]);
    for (int n = 0; n < 6; n++) run_frame(0, q[n], n < 5, n < 5 ? q[n+1] : 8'h00, 1'b0);
    check_idle(0, "after_stream");
  endtask
  task automatic test_parity;
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    for (int n = 0; n < 3; n++) begin
      send(1, 8'($urandom), 1'b1);
      send(2, 8'($urandom), 1'b1);
    end
  endtask
  task automatic test_stop2;
    send(3, 8'h3C, 1'b1);
    start(3, 8'($urandom) | 8'h81);
    run_frame(3, data[3], 1'b1, 8'($urandom), 1'b0);
    run_frame(3, data[3], 1'b0, 8'h00, 1'b1);
    check_idle(3, "after_stop2_stream");
  endtask
  task automatic test_mid_reset;
    start(0, 8'($urandom));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) valid[0] = 1'b0;
    end
    rst = 1'b1;
    check_idle(0, "mid_reset");
    rst = 1'b0;
    send(0, 8'($urandom), 1'b0);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    test_reset;
    test_idle;
    test_single;
    test_back_to_back;
    test_parity;
    test_stop2;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
